// File: rtl/adc_pipe_stage_gen_pkg.sv
// adc_pipe_stage_gen_pkg
//   Shared definitions for the pipelined-ADC stage-decision generator:
//   - adc_state_e : sequencer FSM state encoding
//   - PIN_*       : one-hot pin patterns for a stage decision value
//   - decomp_t    : one code split into stage-1, stage-2 and last-stage parts
//   - pin_onehot(): decision value -> pin pattern
//   - decompose() : code -> (b1, b2, d3), canonical or redundant
package adc_pipe_stage_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } adc_state_e;

  // Pin order is not value order: the middle pin carries value 0.
  localparam logic [2:0] PIN_IDLE = 3'b000;
  localparam logic [2:0] PIN_V0   = 3'b010;
  localparam logic [2:0] PIN_V1   = 3'b001;
  localparam logic [2:0] PIN_V2   = 3'b100;

  localparam logic [2:0] MAX_CODE = 3'd7;

  typedef struct packed {
    logic [1:0] b1;  // stage-1 decision, 0..2, weight 2
    logic [1:0] b2;  // stage-2 decision, 0..2, weight 1
    logic       d3;  // last-stage bit, weight 1
  } decomp_t;

  function automatic logic [2:0] pin_onehot(input logic [1:0] v);
    logic [2:0] pins;
    case (v)
      2'd0:    pins = PIN_V0;
      2'd1:    pins = PIN_V1;
      2'd2:    pins = PIN_V2;
      default: pins = PIN_IDLE;
    endcase
    return pins;
  endfunction

  // C = 2*b1 + b2 + d3. Canonical form takes the largest b1 that fits.
  // The redundant form moves one unit of stage-1 weight down into the
  // residue whenever the residue would otherwise be 0 or 1, so the later
  // stages carry more of the code.
  function automatic decomp_t decompose(input logic [2:0] code,
                                        input logic       redun);
    decomp_t    res;
    logic [1:0] b1;
    logic [1:0] r;
    if (code >= 3'd4)      b1 = 2'd2;
    else if (code >= 3'd2) b1 = 2'd1;
    else                   b1 = 2'd0;
    // Residue never exceeds 3, so two bits hold it.
    r = 2'(code - {b1, 1'b0});
    if (redun && (b1 != 2'd0) && (r <= 2'd1)) begin
      b1 = b1 - 2'd1;
      r  = r + 2'd2;
    end
    res.b1 = b1;
    res.d3 = r[0];
    res.b2 = {r[1], 1'b0};  // r - d3 is 0 or 2
    return res;
  endfunction

endpackage

// File: rtl/adc_pipe_skew_line.sv
// adc_pipe_skew_line
//   Fixed-depth register delay line. dout is din delayed by DEPTH clocks.
//   All stages clear to zero on reset, so a zero-valued input doubles as
//   the idle/invalid token travelling through the line.
// Ports:
//   clock_i  : clock, rising edge
//   reset_i  : asynchronous active-low reset
//   din_i    : WIDTH-bit input
//   dout_o   : WIDTH-bit output, DEPTH cycles late
module adc_pipe_skew_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = din_i;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/adc_pipe_stage_gen.sv
// adc_pipe_stage_gen
//   Generates the skewed per-stage decisions a 3-stage pipelined ADC would
//   produce for a sequence of target codes, together with a delayed copy of
//   the target code for comparison downstream.
// Ports:
//   clock_i      : clock, rising edge
//   reset_i      : asynchronous active-low reset
//   start_i      : begin a sequence (accepted only in IDLE)
//   stop_i       : abort a running sequence (effective only in RUN)
//   mode_i       : 0 = single code_i, 1 = ramp 0..7 (sampled with start_i)
//   redun_i      : 1 = redundant decomposition (sampled with start_i)
//   code_i       : target code in single mode (sampled with start_i)
//   d1_o         : stage-1 one-hot decision, slot t
//   d2_o         : stage-2 one-hot decision, slot t+1
//   d3_o         : last-stage bit, slot t+2
//   busy_o       : sequence in progress (RUN, DRAIN, DONE)
//   done_o       : one-cycle pulse at sequence end
//   expected_o   : target code, slot t+2+EXP_LAT
//   exp_valid_o  : qualifies expected_o
//   dbg_state_o  : current FSM state
//
// Output qualification: there is no backpressure. exp_valid_o is a pure
// valid strobe; expected_o is meaningful only in cycles where it is high and
// each high cycle corresponds to exactly one cycle in which a code was
// presented on d1_o. d1_o/d2_o use all-zero as their "no data" value.
module adc_pipe_stage_gen
  import adc_pipe_stage_gen_pkg::*;
#(
  parameter int HOLD    = 1,
  parameter int EXP_LAT = 2
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       mode_i,
  input  logic       redun_i,
  input  logic [2:0] code_i,
  output logic [2:0] d1_o,
  output logic [2:0] d2_o,
  output logic       d3_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [2:0] expected_o,
  output logic       exp_valid_o,
  output logic [1:0] dbg_state_o
);

  localparam int HOLD_W    = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int DRAIN_CYC = 2 + EXP_LAT;
  localparam int DRN_W     = $clog2(DRAIN_CYC);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD - 1);
  localparam logic [DRN_W-1:0]  DRAIN_LAST = DRN_W'(DRAIN_CYC - 1);

  adc_state_e        state_q, state_d;
  logic [2:0]        code_q,  code_d;
  logic              mode_q,  mode_d;
  logic              redun_q, redun_d;
  logic [HOLD_W-1:0] hold_q,  hold_d;
  logic [DRN_W-1:0]  drain_q, drain_d;

  // ---------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
      code_q  <= 3'd0;
      mode_q  <= 1'b0;
      redun_q <= 1'b0;
      hold_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      mode_q  <= mode_d;
      redun_q <= redun_d;
      hold_q  <= hold_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    mode_d  = mode_q;
    redun_d = redun_q;
    hold_d  = hold_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUN;
          mode_d  = mode_i;
          redun_d = redun_i;
          code_d  = mode_i ? 3'd0 : code_i;
          hold_d  = '0;
        end
      end
      ST_RUN: begin
        // The code presented in the stop cycle is already on d1_o, so it
        // still completes; stop only prevents any further codes.
        if (stop_i) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end else if (hold_q == HOLD_LAST) begin
          if (!mode_q || (code_q == MAX_CODE)) begin
            state_d = ST_DRAIN;
            drain_d = '0;
          end else begin
            code_d = code_q + 3'd1;
            hold_d = '0;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        // Long enough for the last presented slot to leave expected_o.
        if (drain_q == DRAIN_LAST) begin
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Slot datapath: decide at slot t, then skew later stages
  // ---------------------------------------------------------------------
  logic       slot_vld;
  decomp_t    dec;
  logic [2:0] d2_in;
  logic       d3_in;
  logic [3:0] exp_in;
  logic [3:0] exp_out;

  assign slot_vld = (state_q == ST_RUN);
  assign dec      = decompose(code_q, redun_q);

  assign d1_o   = slot_vld ? pin_onehot(dec.b1) : PIN_IDLE;
  assign d2_in  = slot_vld ? pin_onehot(dec.b2) : PIN_IDLE;
  assign d3_in  = slot_vld & dec.d3;
  assign exp_in = {slot_vld, (slot_vld ? code_q : 3'd0)};

  adc_pipe_skew_line #(.WIDTH(3), .DEPTH(1)) u_d2_line (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .din_i   (d2_in),
    .dout_o  (d2_o)
  );

  adc_pipe_skew_line #(.WIDTH(1), .DEPTH(2)) u_d3_line (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .din_i   (d3_in),
    .dout_o  (d3_o)
  );

  adc_pipe_skew_line #(.WIDTH(4), .DEPTH(2 + EXP_LAT)) u_exp_line (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .din_i   (exp_in),
    .dout_o  (exp_out)
  );

  assign exp_valid_o = exp_out[3];
  assign expected_o  = exp_out[2:0];

  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_adc_pipe_stage_gen.sv
module tb_adc_pipe_stage_gen;

  localparam int HOLD    = 2;
  localparam int EXP_LAT = 2;

  // ---------------- clock / reset ----------------
  logic       clock_i = 1'b0;
  logic       reset_i = 1'b0;
  logic       start_i = 1'b0;
  logic       stop_i  = 1'b0;
  logic       mode_i  = 1'b0;
  logic       redun_i = 1'b0;
  logic [2:0] code_i  = 3'd0;
  logic [2:0] d1_o;
  logic [2:0] d2_o;
  logic       d3_o;
  logic       busy_o;
  logic       done_o;
  logic [2:0] expected_o;
  logic       exp_valid_o;
  logic [1:0] dbg_state_o;

  always #5 clock_i = ~clock_i;

  adc_pipe_stage_gen #(.HOLD(HOLD), .EXP_LAT(EXP_LAT)) dut (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .mode_i      (mode_i),
    .redun_i     (redun_i),
    .code_i      (code_i),
    .d1_o        (d1_o),
    .d2_o        (d2_o),
    .d3_o        (d3_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .expected_o  (expected_o),
    .exp_valid_o (exp_valid_o),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- scoreboard state ----------------
  int vectors     = 0;
  int miscompares = 0;

  logic [2:0] exp_d1_q[$];
  logic [2:0] exp_d2_q[$];
  logic [0:0] exp_d3_q[$];
  logic [2:0] exp_q[$];
  int         due_d2[$];
  int         due_d3[$];
  int         due_exp[$];

  int cyc          = 0;
  int done_cnt     = 0;
  int last_exp_cyc = -1;

  function automatic void check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // ---------------- reference model ----------------
  // Split C into weight-2, weight-1 and weight-1 parts from the arithmetic
  // rules: largest stage-1 digit first, optionally giving one stage-1 unit
  // back to the residue when the residue is small.
  function automatic void model(input int c, input bit redun,
                                output int b1, output int b2, output int d3);
    int hi;
    int r;
    hi = c / 2;
    if (hi > 2) hi = 2;
    r = c - 2 * hi;
    if (redun && hi > 0 && r <= 1) begin
      hi = hi - 1;
      r  = r + 2;
    end
    d3 = r % 2;
    b2 = r - d3;
    b1 = hi;
  endfunction

  function automatic logic [2:0] pin(input int v);
    case (v)
      0:       return 3'b010;
      1:       return 3'b001;
      2:       return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic int pending();
    return exp_d1_q.size() + exp_d2_q.size() + exp_d3_q.size() + exp_q.size()
         + due_d2.size() + due_d3.size() + due_exp.size();
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clock_i) begin
    cyc++;
    if (reset_i) begin
      if (d1_o != 3'b000) begin
        if (exp_d1_q.size() > 0) check("d1", int'(d1_o), int'(exp_d1_q.pop_front()));
        else                     check("d1_spurious", int'(d1_o), 0);
        due_d2.push_back(cyc + 1);
        due_d3.push_back(cyc + 2);
        due_exp.push_back(cyc + 2 + EXP_LAT);
      end

      if (due_d2.size() > 0 && due_d2[0] == cyc) begin
        void'(due_d2.pop_front());
        check("d2", int'(d2_o), (exp_d2_q.size() > 0) ? int'(exp_d2_q.pop_front()) : 0);
      end else begin
        check("d2_idle", int'(d2_o), 0);
      end

      if (due_d3.size() > 0 && due_d3[0] == cyc) begin
        void'(due_d3.pop_front());
        check("d3", int'(d3_o), (exp_d3_q.size() > 0) ? int'(exp_d3_q.pop_front()) : 0);
      end else begin
        check("d3_idle", int'(d3_o), 0);
      end

      if (due_exp.size() > 0 && due_exp[0] == cyc) begin
        void'(due_exp.pop_front());
        check("exp_valid", int'(exp_valid_o), 1);
        check("expected", int'(expected_o), (exp_q.size() > 0) ? int'(exp_q.pop_front()) : -1);
        last_exp_cyc = cyc;
      end else begin
        check("exp_valid_idle", int'(exp_valid_o), 0);
      end

      if (done_o) begin
        done_cnt++;
        check("done_timing", cyc, last_exp_cyc + 1);
        check("done_flushed", pending(), 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // stop_at < 0: no stop; otherwise stop_i is pulsed in cycle stop_at
  // counted from the first cycle after the start edge.
  task automatic run_seq(input bit mode, input bit redun, input logic [2:0] code,
                         input int stop_at);
    int total;
    int n;
    int b1;
    int b2;
    int d3;
    int cv;
    int done_before;
    bit seen;
    total = mode ? 8 * HOLD : HOLD;
    n = (stop_at >= 0 && stop_at + 1 < total) ? stop_at + 1 : total;
    for (int i = 0; i < n; i++) begin
      cv = mode ? i / HOLD : int'(code);
      model(cv, redun, b1, b2, d3);
      check("model_sum", 2 * b1 + b2 + d3, cv);
      exp_d1_q.push_back(pin(b1));
      exp_d2_q.push_back(pin(b2));
      exp_d3_q.push_back(d3[0:0]);
      exp_q.push_back(cv[2:0]);
    end
    done_before = done_cnt;
    check("busy_before_start", int'(busy_o), 0);
    start_i = 1'b1;
    mode_i  = mode;
    redun_i = redun;
    code_i  = code;
    @(posedge clock_i); #1;
    start_i = 1'b0;
    mode_i  = 1'($urandom);
    redun_i = 1'($urandom);
    code_i  = 3'($urandom);
    check("busy_after_start", int'(busy_o), 1);
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      start_i = (c == 1);  // must be ignored: sequence already running
      stop_i  = (c == stop_at);
      @(posedge clock_i); #1;
      if (done_cnt != done_before) seen = 1'b1;
    end
    start_i = 1'b0;
    stop_i  = 1'b0;
    if (!seen) begin
      miscompares++;
      vectors++;
      $display("FAIL done_timeout: got no done_o, want one within 300 cycles");
    end
    repeat (3) @(posedge clock_i);
    #1;
    check("done_once", done_cnt - done_before, 1);
    check("busy_after_done", int'(busy_o), 0);
    check("queues_empty", pending(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_d1"},    int'(d1_o), 0);
    check({tag, "_d2"},    int'(d2_o), 0);
    check({tag, "_d3"},    int'(d3_o), 0);
    check({tag, "_busy"},  int'(busy_o), 0);
    check({tag, "_done"},  int'(done_o), 0);
    check({tag, "_exp"},   int'(expected_o), 0);
    check({tag, "_expv"},  int'(exp_valid_o), 0);
    check({tag, "_state"}, int'(dbg_state_o), 0);
  endtask

  task automatic reset_mid_run();
    int b1;
    int b2;
    int d3;
    int done_before;
    for (int i = 0; i < 8 * HOLD; i++) begin
      model(i / HOLD, 1'b0, b1, b2, d3);
      exp_d1_q.push_back(pin(b1));
      exp_d2_q.push_back(pin(b2));
      exp_d3_q.push_back(d3[0:0]);
      exp_q.push_back(3'(i / HOLD));
    end
    start_i = 1'b1;
    mode_i  = 1'b1;
    redun_i = 1'b0;
    @(posedge clock_i); #1;
    start_i = 1'b0;
    repeat (7) @(posedge clock_i);
    #2;
    reset_i = 1'b0;
    #1;
    check_all_zero("async_reset");
    exp_d1_q.delete();
    exp_d2_q.delete();
    exp_d3_q.delete();
    exp_q.delete();
    due_d2.delete();
    due_d3.delete();
    due_exp.delete();
    @(posedge clock_i); #1;
    check_all_zero("held_reset");
    reset_i = 1'b1;
    done_before = done_cnt;
    repeat (12) @(posedge clock_i);
    #1;
    check("no_done_after_reset", done_cnt - done_before, 0);
    check("busy_after_reset", int'(busy_o), 0);
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    #3;
    check_all_zero("reset");
    repeat (2) @(posedge clock_i);
    #1;
    reset_i = 1'b1;
    @(posedge clock_i); #1;
    check_all_zero("idle");

    // stop_i in IDLE must do nothing
    stop_i = 1'b1;
    @(posedge clock_i); #1;
    stop_i = 1'b0;
    check("stop_in_idle_state", int'(dbg_state_o), 0);

    run_seq(1'b0, 1'b0, 3'd5, -1);           // canonical 5: 100 / 010 / 1
    run_seq(1'b0, 1'b1, 3'd5, -1);           // redundant 5: 001 / 100 / 1
    run_seq(1'b1, 1'b0, 3'd0, -1);           // full ramp
    run_seq(1'b1, 1'b1, 3'd0, -1);           // full ramp, redundant
    run_seq(1'b1, 1'b0, 3'd0, 3 * HOLD);     // stop on first cycle of code 3
    run_seq(1'b0, 1'b0, 3'd7, HOLD + 1);     // stop lands in DRAIN
    run_seq(1'b0, 1'b1, 3'd0, -1);           // no redundant form for 0
    run_seq(1'b0, 1'b1, 3'd7, 0);            // stop in first RUN cycle

    for (int k = 0; k < 20; k++) begin
      bit         m;
      bit         r;
      logic [2:0] c;
      int         sa;
      m  = 1'($urandom);
      r  = 1'($urandom);
      c  = 3'($urandom);
      sa = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 8 * HOLD + 4));
      run_seq(m, r, c, sa);
      repeat ($urandom_range(0, 3)) @(posedge clock_i);
      #1;
    end

    reset_mid_run();
    run_seq(1'b0, 1'b0, 3'd3, -1);           // clean sequence after reset

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adc_pipe_stage_gen.md
ADC_PIPE_STAGE_GEN -- requirements
Module: adc_pipe_stage_gen

Interface
REQ-001 Parameter HOLD, default 1: clock cycles each code is presented (≥1).
REQ-002 Parameter EXP_LAT, default 2: extra delay of expected_o relative to the d3_o slot.
REQ-003 clock_i  input  1  single clock; all state on rising edge.
REQ-004 reset_i  input  1  asynchronous active-low reset.
REQ-005 start_i  input  1  begin a sequence; sampled only in IDLE.
REQ-006 stop_i   input  1  abort a running sequence.
REQ-007 mode_i   input  1  0 = single code from code_i, 1 = ramp 0..7; sampled with start_i.
REQ-008 redun_i  input  1  1 = emit the redundant decomposition where one exists; sampled with start_i.
REQ-009 code_i   input  3  target code for single mode; sampled with start_i.
REQ-010 d1_o     output 3  stage-1 one-hot decision, pin-ordered.
REQ-011 d2_o     output 3  stage-2 one-hot decision, pin-ordered.
REQ-012 d3_o     output 1  last-stage bit.
REQ-013 busy_o   output 1  high from the cycle after accepted start until the cycle done_o pulses.
REQ-014 done_o   output 1  one-cycle pulse at sequence end (normal or aborted).
REQ-015 expected_o output 3 target code whose stage data has fully left the block.
REQ-016 exp_valid_o output 1 qualifies expected_o.

Function
REQ-017 Decomposition SHALL satisfy C = 2*b1 + b2 + d3, b1,b2 in 0..2, d3 in 0..1.
REQ-018 Canonical: b1 = 2 if C≥4, 1 if C≥2, else 0; r = C-2*b1; d3 = r[0]; b2 = r-d3.
REQ-019 Redundant (redun_i=1): if b1>0 and r≤1, use b1-1 and r+2 then REQ-018 split; otherwise canonical.
REQ-020 Pin one-hot mapping SHALL be: value 0 -> 3'b010, value 1 -> 3'b001, value 2 -> 3'b100; idle value 3'b000.
REQ-021 Skew: b1 of a code appears on d1_o at cycle t, its b2 on d2_o at t+1, its d3 on d3_o at t+2.
REQ-022 expected_o/exp_valid_o SHALL present the code at t+2+EXP_LAT, one valid cycle per presented cycle.
REQ-023 FSM states IDLE, RUN, DRAIN, DONE.
REQ-024 IDLE -> RUN on start_i; start_i while not IDLE SHALL be ignored.
REQ-025 RUN: each code held HOLD cycles; single mode presents one code, ramp presents 0..7 in order without wrap.
REQ-026 RUN -> DRAIN after the last code's final hold cycle, or immediately on stop_i (stop wins over code advance in the same cycle).
REQ-027 DRAIN: new-code slot outputs idle; lasts 2+EXP_LAT cycles so all in-flight data and expected codes flush completely.
REQ-028 DRAIN -> DONE -> IDLE; done_o high during DONE only.
REQ-029 Slots not carrying a presented code SHALL output idle value; exp_valid_o low.
REQ-030 stop_i in IDLE, DRAIN or DONE SHALL have no effect.

Reset
REQ-031 reset_i low SHALL immediately force IDLE, d1_o=d2_o=3'b000, d3_o=0, busy_o=0, done_o=0, expected_o=0, exp_valid_o=0, and clear all skew/delay registers.
REQ-032 Reset mid-sequence SHALL discard in-flight data; no done_o pulse follows release.

Structure
REQ-033 Shared package SHALL hold FSM state encoding, one-hot pin constants (REQ-020), and the decomposition function.
REQ-034 One sub-module adc_pipe_skew_line (parameterised-depth register delay) SHALL implement the d2/d3 and expected-code delays.

Verification
REQ-035 Single mode, code_i=5, redun_i=0, HOLD=1 -> d1_o=100 at t, d2_o=010 at t+1, d3_o=1 at t+2, expected_o=5 valid at t+4, done_o once.
REQ-036 Single, code_i=5, redun_i=1 -> d1_o=001, d2_o=100, d3_o=1; expected_o=5.
REQ-037 Ramp, HOLD=2 -> codes 0..7 each valid 2 cycles on expected_o, 16 valid cycles total, then done_o.
REQ-038 stop_i during ramp at code 3 -> no new codes after, already-launched codes still complete, done_o pulses after drain.
REQ-039 reset_i low during RUN -> all outputs zero asynchronously, busy_o=0, no done_o after release; start_i while busy ignored.
